// File: rtl/peak_phase_detect.sv
// peak_phase_detect: tracks the strongest reference-channel bin of each FFT
// frame and reports every channel's samples at that bin.
// Optional feature macro: PEAK_INTERP_EN adds the peak_bin-1/peak_bin+1
// reference magnitudes on peak_mag_lo/peak_mag_hi; without it both read 0.
module peak_phase_detect #(
    parameter int FFT_DEPTH = 11,
    parameter int FFT_WIDTH = 25,
    parameter int N_CH      = 2,
    parameter int BIN_LO    = 1,
    parameter int BIN_HI    = 2**FFT_DEPTH/2-1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sink_sop,
    input  logic                      sink_eop,
    input  logic                      sink_valid,
    input  logic [N_CH*FFT_WIDTH-1:0] sink_re,
    input  logic [N_CH*FFT_WIDTH-1:0] sink_im,
    output logic                      peak_valid,
    output logic [FFT_DEPTH-1:0]      peak_bin,
    output logic [FFT_WIDTH:0]        peak_mag,
    output logic [N_CH*FFT_WIDTH-1:0] peak_re,
    output logic [N_CH*FFT_WIDTH-1:0] peak_im,
    output logic [FFT_WIDTH:0]        peak_mag_lo,
    output logic [FFT_WIDTH:0]        peak_mag_hi,
    output logic                      frame_err
);

    localparam logic [FFT_DEPTH-1:0] BIN_LAST = '1;
    localparam logic [FFT_DEPTH-1:0] WIN_LO   = FFT_DEPTH'(BIN_LO);
    localparam logic [FFT_DEPTH-1:0] WIN_HI   = FFT_DEPTH'(BIN_HI);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Absolute value widened by one bit so the most negative input is exact.
    function automatic logic [FFT_WIDTH:0] abs_f(input logic [FFT_WIDTH-1:0] v);
        logic [FFT_WIDTH:0] x;
        x = {v[FFT_WIDTH-1], v};
        if (v[FFT_WIDTH-1]) begin
            abs_f = (~x) + {{FFT_WIDTH{1'b0}}, 1'b1};
        end else begin
            abs_f = x;
        end
    endfunction

    state_t                  state_r, nxt_state_s;
    logic [FFT_DEPTH-1:0]    bin_r, cur_bin_s;
    logic                    beat_s, start_s, err_s, upd_s;
    logic [FFT_WIDTH:0]      mag_s;

    logic [FFT_DEPTH-1:0]    best_bin_r, stage_bin_r;
    logic [FFT_WIDTH:0]      best_mag_r, stage_mag_r;
    logic [N_CH*FFT_WIDTH-1:0] best_re_r, best_im_r, stage_re_r, stage_im_r;
    logic                    pend_r;

    assign mag_s = abs_f(sink_re[FFT_WIDTH-1:0]) + abs_f(sink_im[FFT_WIDTH-1:0]);

    // Running-peak update: first window bin always seeds, later bins need a strictly larger magnitude.
    assign upd_s = beat_s && (cur_bin_s >= WIN_LO) && (cur_bin_s <= WIN_HI) &&
                   ((cur_bin_s == WIN_LO) || (mag_s > best_mag_r));

    // Framing state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= nxt_state_s;
        end
    end

    // Beat acceptance, bin numbering and framing-violation detection.
    always_comb begin
        nxt_state_s = state_r;
        beat_s      = 1'b0;
        start_s     = 1'b0;
        err_s       = 1'b0;
        cur_bin_s   = bin_r;
        if (sink_valid && sink_sop) begin
            beat_s    = 1'b1;
            start_s   = 1'b1;
            cur_bin_s = '0;
            err_s     = (state_r == S_RUN);
        end else if (sink_valid && (state_r == S_RUN)) begin
            beat_s = 1'b1;
        end else begin
            beat_s = 1'b0;
        end
        if (beat_s) begin
            if (sink_eop && (cur_bin_s == BIN_LAST)) begin
                nxt_state_s = S_DONE;
            end else if (sink_eop || (cur_bin_s == BIN_LAST)) begin
                err_s       = 1'b1;
                nxt_state_s = S_IDLE;
            end else begin
                nxt_state_s = S_RUN;
            end
        end else if (state_r == S_DONE) begin
            nxt_state_s = S_IDLE;
        end else begin
            nxt_state_s = state_r;
        end
    end

    // Bin counter and running peak capture for the frame in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_r      <= '0;
            best_bin_r <= '0;
            best_mag_r <= '0;
            best_re_r  <= '0;
            best_im_r  <= '0;
        end else begin
            if (beat_s) begin
                bin_r <= cur_bin_s + {{(FFT_DEPTH-1){1'b0}}, 1'b1};
            end
            if (upd_s) begin
                best_bin_r <= cur_bin_s;
                best_mag_r <= mag_s;
                best_re_r  <= sink_re;
                best_im_r  <= sink_im;
            end
        end
    end

    // Two-stage result path: snapshot during DONE, publish one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_r      <= 1'b0;
            stage_bin_r <= '0;
            stage_mag_r <= '0;
            stage_re_r  <= '0;
            stage_im_r  <= '0;
            peak_valid  <= 1'b0;
            peak_bin    <= '0;
            peak_mag    <= '0;
            peak_re     <= '0;
            peak_im     <= '0;
            frame_err   <= 1'b0;
        end else begin
            pend_r     <= (state_r == S_DONE);
            peak_valid <= pend_r;
            frame_err  <= err_s;
            if (state_r == S_DONE) begin
                stage_bin_r <= best_bin_r;
                stage_mag_r <= best_mag_r;
                stage_re_r  <= best_re_r;
                stage_im_r  <= best_im_r;
            end
            if (pend_r) begin
                peak_bin <= stage_bin_r;
                peak_mag <= stage_mag_r;
                peak_re  <= stage_re_r;
                peak_im  <= stage_im_r;
            end
        end
    end

`ifdef PEAK_INTERP_EN
    logic [FFT_WIDTH:0] prev_mag_r, lo_r, hi_r, stage_lo_r, stage_hi_r;
    logic               need_hi_r;

    // Neighbour magnitudes: lower one from the previous beat, upper one from the beat after the peak.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_mag_r <= '0;
            lo_r       <= '0;
            hi_r       <= '0;
            need_hi_r  <= 1'b0;
        end else begin
            if (beat_s) begin
                prev_mag_r <= mag_s;
            end
            if (upd_s) begin
                lo_r      <= (cur_bin_s == '0) ? '0 : prev_mag_r;
                hi_r      <= '0;
                need_hi_r <= (cur_bin_s != BIN_LAST);
            end else if (start_s) begin
                need_hi_r <= 1'b0;
            end else if (beat_s && need_hi_r) begin
                hi_r      <= mag_s;
                need_hi_r <= 1'b0;
            end
        end
    end

    // Neighbour magnitudes follow the same snapshot/publish timing as the peak.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_lo_r  <= '0;
            stage_hi_r  <= '0;
            peak_mag_lo <= '0;
            peak_mag_hi <= '0;
        end else begin
            if (state_r == S_DONE) begin
                stage_lo_r <= lo_r;
                stage_hi_r <= hi_r;
            end
            if (pend_r) begin
                peak_mag_lo <= stage_lo_r;
                peak_mag_hi <= stage_hi_r;
            end
        end
    end
`else
    assign peak_mag_lo = '0;
    assign peak_mag_hi = '0;
`endif

endmodule

// File: tb/tb_peak_phase_detect.sv
// Self-checking bench for peak_phase_detect (FFT_DEPTH=4, FFT_WIDTH=16, N_CH=2).
// Expected peak results are queued when an eop beat is driven and checked
// when peak_valid fires, along with its latency.
module tb_peak_phase_detect;

    localparam int D = 4;
    localparam int W = 16;
    localparam int C = 2;
    localparam int N = 16;
    localparam int LO = 1;
    localparam int HI = 7;

    typedef struct {
        logic [D-1:0]   bin;
        logic [W:0]     mag;
        logic [C*W-1:0] re;
        logic [C*W-1:0] im;
        logic [W:0]     lo;
        logic [W:0]     hi;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sink_sop = 1'b0, sink_eop = 1'b0, sink_valid = 1'b0;
    logic [C*W-1:0] sink_re = '0, sink_im = '0;
    logic peak_valid, frame_err;
    logic [D-1:0] peak_bin;
    logic [W:0] peak_mag, peak_mag_lo, peak_mag_hi;
    logic [C*W-1:0] peak_re, peak_im;

    logic mark_good = 1'b0, mark_bad = 1'b0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fr_re[C][N];
    int fr_im[C][N];
    exp_t exp_q[$];
    int due_q[$];

    peak_phase_detect #(.FFT_DEPTH(D), .FFT_WIDTH(W), .N_CH(C), .BIN_LO(LO), .BIN_HI(HI)) dut (
        .clk(clk), .reset(reset), .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_valid(sink_valid), .sink_re(sink_re), .sink_im(sink_im),
        .peak_valid(peak_valid), .peak_bin(peak_bin), .peak_mag(peak_mag),
        .peak_re(peak_re), .peak_im(peak_im), .peak_mag_lo(peak_mag_lo),
        .peak_mag_hi(peak_mag_hi), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int mag_of(input int b);
        return iabs(fr_re[0][b]) + iabs(fr_im[0][b]);
    endfunction

    // Reference model of the peak search over the current frame tables.
    function automatic exp_t model();
        exp_t e;
        int best;
        int bb;
        best = -1;
        bb = LO;
        for (int b = LO; b <= HI; b++) begin
            if (b == LO || mag_of(b) > best) begin
                best = mag_of(b);
                bb = b;
            end
        end
        e.bin = D'(bb);
        e.mag = (W+1)'(best);
        for (int c = 0; c < C; c++) begin
            e.re[c*W +: W] = W'(fr_re[c][bb]);
            e.im[c*W +: W] = W'(fr_im[c][bb]);
        end
`ifdef PEAK_INTERP_EN
        e.lo = (bb > 0) ? (W+1)'(mag_of(bb-1)) : '0;
        e.hi = (bb < N-1) ? (W+1)'(mag_of(bb+1)) : '0;
`else
        e.lo = '0;
        e.hi = '0;
`endif
        return e;
    endfunction

    task automatic fill_base();
        for (int b = 0; b < N; b++) begin
            fr_re[0][b] = 1;
            fr_im[0][b] = 0;
            fr_re[1][b] = 100 + 7*b;
            fr_im[1][b] = -50 - 3*b;
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        mark_good = 1'b0; mark_bad = 1'b0;
    endtask

    task automatic beat(input logic sop, input logic eop, input int b, input logic good, input logic bad);
        @(negedge clk);
        sink_valid = 1'b1; sink_sop = sop; sink_eop = eop;
        mark_good = good; mark_bad = bad;
        for (int c = 0; c < C; c++) begin
            sink_re[c*W +: W] = W'(fr_re[c][b]);
            sink_im[c*W +: W] = W'(fr_im[c][b]);
        end
    endtask

    // Sends one frame; stop_bin >= 0 ends it early with an illegal eop.
    task automatic send_frame(input logic gaps, input logic first_bad, input int stop_bin);
        for (int b = 0; b < N; b++) begin
            if (b == stop_bin) begin
                beat(1'b0, 1'b1, b, 1'b0, 1'b1);
                return;
            end else if (b == N-1) begin
                exp_q.push_back(model());
                beat(1'b0, 1'b1, b, 1'b1, 1'b0);
            end else begin
                beat(b == 0, 1'b0, b, 1'b0, (b == 0) && first_bad);
            end
            if (gaps && b != N-1) idle_cycle();
        end
    endtask

    // Scoreboard monitor: frame_err and peak_valid timing/content, sampled 1ns after each edge.
    always @(posedge clk) begin
        logic saw_good, saw_bad;
        exp_t e;
        cyc++;
        saw_good = sink_valid && mark_good && !reset;
        saw_bad  = sink_valid && mark_bad && !reset;
        #1;
        if (saw_good) due_q.push_back(cyc + 2);
        if (saw_bad || frame_err) begin
            checks++;
            if (frame_err !== saw_bad) begin
                errors++;
                $display("FAIL frame_err cyc=%0d got=%b want=%b", cyc, frame_err, saw_bad);
            end
        end
        if (peak_valid) begin
            checks++;
            if (due_q.size() == 0 || due_q[0] != cyc) begin
                errors++;
                $display("FAIL peak_valid_timing cyc=%0d due=%0d", cyc, (due_q.size() > 0) ? due_q[0] : -1);
            end
            if (due_q.size() > 0) void'(due_q.pop_front());
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (peak_bin !== e.bin) begin errors++; $display("FAIL peak_bin got=%0d want=%0d", peak_bin, e.bin); end
                checks++;
                if (peak_mag !== e.mag) begin errors++; $display("FAIL peak_mag got=%0d want=%0d", peak_mag, e.mag); end
                checks++;
                if (peak_re !== e.re || peak_im !== e.im) begin
                    errors++;
                    $display("FAIL peak_samples got=%h/%h want=%h/%h", peak_re, peak_im, e.re, e.im);
                end
                checks++;
                if (peak_mag_lo !== e.lo || peak_mag_hi !== e.hi) begin
                    errors++;
                    $display("FAIL peak_neighbours got=%0d/%0d want=%0d/%0d", peak_mag_lo, peak_mag_hi, e.lo, e.hi);
                end
            end
        end else if (due_q.size() > 0 && due_q[0] < cyc + 1 && due_q[0] <= cyc) begin
            checks++;
            errors++;
            $display("FAIL peak_valid_missing cyc=%0d due=%0d", cyc, due_q[0]);
            void'(due_q.pop_front());
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
    end

    task automatic check_zero(input string name);
        checks++;
        if (peak_valid !== 1'b0 || peak_bin !== '0 || peak_mag !== '0 || peak_re !== '0 ||
            peak_im !== '0 || peak_mag_lo !== '0 || peak_mag_hi !== '0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL %s got valid=%b bin=%0d mag=%0d re=%h im=%h lo=%0d hi=%0d err=%b want all 0",
                     name, peak_valid, peak_bin, peak_mag, peak_re, peak_im, peak_mag_lo, peak_mag_hi, frame_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset_outputs");
        reset = 1'b0;
    endtask

    task automatic test_tone();
        fill_base();
        fr_re[0][5] = 1000;
        fr_im[0][5] = -200;
        beat(1'b0, 1'b0, 3, 1'b0, 1'b0);
        beat(1'b0, 1'b0, 4, 1'b0, 1'b0);
        send_frame(1'b0, 1'b0, -1);
        idle_cycle();
    endtask

    task automatic test_tie();
        fill_base();
        fr_re[0][3] = 500;
        fr_re[0][6] = 250;
        fr_im[0][6] = -250;
        send_frame(1'b0, 1'b0, -1);
        idle_cycle();
    endtask

    task automatic test_interp();
        fill_base();
        fr_re[0][4] = 900;
        fr_re[0][3] = 0;
        fr_im[0][3] = 300;
        fr_re[0][5] = -450;
        send_frame(1'b0, 1'b0, -1);
        idle_cycle();
    endtask

    task automatic test_eop_err();
        fill_base();
        fr_re[0][2] = 77;
        send_frame(1'b0, 1'b0, 9);
        idle_cycle();
        repeat (4) idle_cycle();
        fr_re[0][6] = 3000;
        send_frame(1'b0, 1'b0, -1);
        idle_cycle();
    endtask

    task automatic test_mid_reset();
        fill_base();
        for (int b = 0; b <= 8; b++) beat(b == 0, 1'b0, b, 1'b0, 1'b0);
        @(negedge clk);
        sink_valid = 1'b0; sink_sop = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_zero("mid_frame_reset");
        reset = 1'b0;
        fr_re[0][2] = -600;
        fr_im[0][2] = 40;
        send_frame(1'b0, 1'b0, -1);
        idle_cycle();
    endtask

    task automatic test_min_gaps();
        fill_base();
        fr_re[0][7] = -32768;
        fr_im[0][7] = 0;
        send_frame(1'b1, 1'b0, -1);
        idle_cycle();
    endtask

    task automatic test_all_zero();
        fill_base();
        for (int b = 0; b < N; b++) fr_re[0][b] = 0;
        send_frame(1'b0, 1'b0, -1);
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        fill_base();
        fr_im[0][6] = 1234;
        send_frame(1'b0, 1'b0, -1);
        fr_im[0][6] = 0;
        fr_re[0][1] = -2222;
        send_frame(1'b0, 1'b0, -1);
        idle_cycle();
    endtask

    task automatic test_sop_restart();
        fill_base();
        for (int b = 0; b <= 4; b++) beat(b == 0, 1'b0, b, 1'b0, 1'b0);
        fr_im[0][4] = -4321;
        send_frame(1'b0, 1'b1, -1);
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_tone();
        test_tie();
        test_interp();
        test_eop_err();
        test_mid_reset();
        test_min_gaps();
        test_all_zero();
        test_back_to_back();
        test_sop_restart();
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_results got=%0d want=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
